// File: rtl/aes_pkg.sv
// aes_pkg: AES byte-substitution tables and the SubBytes engine state type,
// shared by every S-box consumer (SubBytes engine, key expansion).
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sb_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_dual.sv
// sbox_dual: one combinational byte lookup through the forward or inverse
// AES S-box, selected per block by i_inv.
module sbox_dual
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_inv,
    output logic [7:0] o_byte
);

    // Table select; the caller registers the result.
    always_comb begin
        o_byte = i_inv ? INV_SBOX[i_byte] : SBOX[i_byte];
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: folded AES SubBytes / InvSubBytes over one 128-bit state.
// LANES bytes are substituted per clock, so a block spends 16/LANES cycles in
// RUN, then waits in DONE until the consumer takes it. A new block may be
// accepted in the same cycle the finished one is consumed.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N          = 16 / LANES;
    localparam int CW         = (N > 1) ? $clog2(N) : 1;
    localparam int LANE_SHIFT = $clog2(LANES) + 3;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e      r_state;
    sb_state_e      w_next_state;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_src;
    logic [127:0]   r_res;
    logic           r_mode;
    logic           w_accept;
    logic [6:0]     w_bit_base;
    logic [7:0]     w_lane_in  [LANES];
    logic [7:0]     w_lane_out [LANES];

    // Bit offset of the first byte handled this cycle: cnt * LANES * 8.
    if (N == 1) begin : g_single_pass
        assign w_bit_base = '0;
    end else begin : g_multi_pass
        assign w_bit_base = 7'(r_cnt) << LANE_SHIFT;
    end

    // One S-box per lane, all sharing the block's latched mode.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_in[k] = r_src[w_bit_base + 7'(8 * k) +: 8];

        sbox_dual u_sbox (
            .i_byte (w_lane_in[k]),
            .i_inv  (r_mode),
            .o_byte (w_lane_out[k])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and input handshake; in_ready sees out_ready directly.
    always_comb begin
        // NOTE: defaults first so every path drives every signal and no latch is inferred.
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    in_ready     = 1'b1;
                    w_next_state = in_valid ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && in_ready;

    // Datapath: capture on accept, substitute LANES bytes per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are reset because their reset value is visible on out_data.
        if (rst) begin
            r_cnt  <= '0;
            r_src  <= '0;
            r_mode <= 1'b0;
            r_res  <= '0;
        end else begin
            if (w_accept) begin
                r_src  <= in_data;
                r_mode <= in_inv;
                r_cnt  <= '0;
            end
            if (r_state == ST_RUN) begin
                for (int k = 0; k < LANES; k++) begin
                    r_res[w_bit_base + 7'(8 * k) +: 8] <= w_lane_out[k];
                end
                if (r_cnt != CNT_LAST) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN);
    assign out_data  = r_res;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: one engine per legal LANES value (index g has
// LANES = 1 << g), checked against S-box tables derived from GF(2^8)
// inversion plus the AES affine map.
module tb_sub_bytes_engine;

    localparam int NI = 5;
    localparam logic [127:0] V_PLAIN = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] V_SUB   = 128'h76abd7fe2b670130c56f6bf27b777c63;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [127:0] in_data   [NI];
    logic         in_inv    [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] out_data  [NI];
    logic         busy      [NI];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_sbox [256];
    logic [7:0] m_inv  [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_bytes_engine #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_model();
        logic [7:0] b;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            b = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gf_mul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
            end
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            m_sbox[a] = s;
            m_inv[s]  = 8'(a);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = inv ? m_inv[d[8*i +: 8]] : m_sbox[d[8*i +: 8]];
        end
        return r;
    endfunction

    // ---------------- drivers ----------------
    // Offer a block to an idle engine, then scramble the inputs after accept.
    task automatic offer(input int idx, input logic [127:0] d, input logic inv);
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        in_inv[idx]   = inv;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = ~d;
        in_inv[idx]   = ~inv;
    endtask

    // Edges from accept until out_valid (-1 on timeout) and RUN cycles seen.
    task automatic wait_out(input int idx, output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy[idx]) busy_cnt++;
            if (out_valid[idx]) begin
                lat = c - 1;
                break;
            end
        end
    endtask

    task automatic consume(input int idx);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || out_data[i] !== 128'h0) begin
                $display("FAIL reset[%0d]: rdy=%b vld=%b busy=%b data=%h, need 1/0/0/0", i, in_ready[i], out_valid[i], busy[i], out_data[i]);
            end else n_pass++;
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0) begin
                $display("FAIL post_reset[%0d]: rdy=%b vld=%b, need 1/0", i, in_ready[i], out_valid[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_fwd_l16();
        int lat, bc;
        offer(4, V_PLAIN, 1'b0);
        wait_out(4, lat, bc);
        n_checks++;
        if (lat !== 1) $display("FAIL l16_latency: got %0d, need 1", lat); else n_pass++;
        n_checks++;
        if (out_data[4] !== V_SUB) $display("FAIL l16_vector: got %h, need %h", out_data[4], V_SUB); else n_pass++;
        n_checks++;
        if (out_data[4] !== ref_sub(V_PLAIN, 1'b0)) $display("FAIL l16_model: got %h, need %h", out_data[4], ref_sub(V_PLAIN, 1'b0)); else n_pass++;
        consume(4);
    endtask

    task automatic test_inv_l4();
        int lat, bc;
        offer(2, V_SUB, 1'b1);
        wait_out(2, lat, bc);
        n_checks++;
        if (lat !== 4) $display("FAIL l4_latency: got %0d, need 4", lat); else n_pass++;
        n_checks++;
        if (bc !== 4) $display("FAIL l4_busy_cycles: got %0d, need 4", bc); else n_pass++;
        n_checks++;
        if (out_data[2] !== V_PLAIN) $display("FAIL l4_round_trip: got %h, need %h", out_data[2], V_PLAIN); else n_pass++;
        consume(2);
    endtask

    task automatic test_hold_l1();
        int lat, bc;
        logic [127:0] snap;
        offer(0, {16{8'h53}}, 1'b0);
        wait_out(0, lat, bc);
        n_checks++;
        if (lat !== 16) $display("FAIL l1_latency: got %0d, need 16", lat); else n_pass++;
        n_checks++;
        if (out_data[0] !== {16{8'hed}}) $display("FAIL l1_value: got %h, need %h", out_data[0], {16{8'hed}}); else n_pass++;
        snap = out_data[0];
        in_valid[0] = 1'b1;
        in_data[0]  = 128'h1234;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== snap || in_ready[0] !== 1'b0) begin
                $display("FAIL l1_hold: vld=%b rdy=%b data=%h, need 1/0/%h", out_valid[0], in_ready[0], out_data[0], snap);
            end else n_pass++;
        end
        in_valid[0] = 1'b0;
        consume(0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] da, db, o0, o1;
        logic rdy0;
        int t0, t1;
        t0 = -1;
        t1 = -1;
        rdy0 = 1'b0;
        o0 = '0;
        o1 = '0;
        da = {$urandom(), $urandom(), $urandom(), $urandom()};
        db = {$urandom(), $urandom(), $urandom(), $urandom()};
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        in_data[2]   = da;
        in_inv[2]    = 1'b0;
        @(posedge clk);
        #1;
        in_data[2] = db;
        in_inv[2]  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (t0 >= 0 && in_valid[2]) begin
                in_valid[2] = 1'b0;
                in_inv[2]   = 1'b0;
            end
            if (out_valid[2]) begin
                if (t0 < 0) begin
                    t0 = c; o0 = out_data[2]; rdy0 = in_ready[2];
                end else begin
                    t1 = c; o1 = out_data[2];
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b0;
        n_checks++;
        if (rdy0 !== 1'b1) $display("FAIL b2b_accept_on_handshake: in_ready=%b, need 1", rdy0); else n_pass++;
        n_checks++;
        if (t0 < 0 || t1 < 0 || t1 - t0 !== 5) $display("FAIL b2b_spacing: t0=%0d t1=%0d, need gap 5", t0, t1); else n_pass++;
        n_checks++;
        if (o0 !== ref_sub(da, 1'b0)) $display("FAIL b2b_first_fwd: got %h, need %h", o0, ref_sub(da, 1'b0)); else n_pass++;
        n_checks++;
        if (o1 !== ref_sub(db, 1'b1)) $display("FAIL b2b_second_inv: got %h, need %h", o1, ref_sub(db, 1'b1)); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, stray;
        offer(1, 128'h00112233445566778899aabbccddeeff, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid[1] !== 1'b0 || out_data[1] !== 128'h0 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            $display("FAIL midrun_reset: vld=%b rdy=%b busy=%b data=%h, need 0/1/0/0", out_valid[1], in_ready[1], busy[1], out_data[1]);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid[1] !== 1'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) $display("FAIL midrun_discard: out_valid seen %0d cycles, need 0", stray); else n_pass++;
        offer(1, 128'h0, 1'b0);
        wait_out(1, lat, bc);
        n_checks++;
        if (lat !== 8) $display("FAIL l2_latency: got %0d, need 8", lat); else n_pass++;
        n_checks++;
        if (out_data[1] !== {16{8'h63}}) $display("FAIL l2_zero_block: got %h, need %h", out_data[1], {16{8'h63}}); else n_pass++;
        consume(1);
    endtask

    task automatic rand_stream(input int idx, input int nblk);
        logic [127:0] q_exp [$];
        logic [127:0] d, hold_d;
        logic m, hold_v;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        hold_v = 1'b0; hold_d = '0; d = '0; m = 1'b0;
        while (got < nblk && cyc < nblk * 40) begin
            @(negedge clk);
            cyc++;
            if (hold_v) begin
                n_checks++;
                if (out_valid[idx] !== 1'b1 || out_data[idx] !== hold_d) begin
                    $display("FAIL rand_stable[%0d]: vld=%b data=%h, need 1/%h", idx, out_valid[idx], out_data[idx], hold_d);
                end else n_pass++;
            end
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            m = 1'($urandom_range(0, 1));
            in_valid[idx]  = (sent < nblk) && ($urandom_range(0, 3) != 0);
            in_data[idx]   = d;
            in_inv[idx]    = m;
            out_ready[idx] = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid[idx] && in_ready[idx]) begin
                q_exp.push_back(ref_sub(d, m));
                sent++;
            end
            hold_v = out_valid[idx] && !out_ready[idx];
            hold_d = out_data[idx];
            if (out_valid[idx] && out_ready[idx]) begin
                n_checks++;
                if (q_exp.size() == 0 || out_data[idx] !== q_exp[0]) begin
                    $display("FAIL rand_data[%0d] blk %0d: got %h, need %h", idx, got, out_data[idx], (q_exp.size() != 0) ? q_exp[0] : 128'hx);
                end else n_pass++;
                if (q_exp.size() != 0) void'(q_exp.pop_front());
                got++;
            end
        end
        @(posedge clk);
        #1;
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b0;
        n_checks++;
        if (got !== nblk) $display("FAIL rand_done[%0d]: got %0d blocks, need %0d", idx, got, nblk); else n_pass++;
    endtask

    task automatic test_random();
        fork
            rand_stream(0, 1000);
            rand_stream(1, 1000);
            rand_stream(2, 1000);
            rand_stream(3, 1000);
            rand_stream(4, 1000);
        join
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_inv[i]    = 1'b0;
            out_ready[i] = 1'b0;
        end
        build_model();
        test_reset();
        test_fwd_l16();
        test_inv_l4();
        test_hold_l1();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
